// File: rtl/sum_accum_pkg.sv
// Shared types and constants for the sum accumulator and the adder stage
// that feeds it.
package sum_pkg;

    // Width of the adder stage's registered sum output.
    localparam int SUM_W = 3;

    // Frame controller states.
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    // Saturating add of two operands, each up to 32 bits, saturating at
    // 2^width-1. The return value is {ovf, result}. The operands are
    // expected to fit in width bits already.
    function automatic logic [32:0] sat_add(input logic [31:0] acc,
                                            input logic [31:0] val,
                                            input int unsigned width);
        logic [32:0] wide;
        logic [31:0] lim;
        lim  = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        wide = {1'b0, acc} + {1'b0, val};
        if (wide > {1'b0, lim}) begin
            sat_add = {1'b1, lim};
        end else begin
            sat_add = wide;
        end
    endfunction

endpackage

// File: rtl/sum_sat_add.sv
// Combinational ACC_W-bit saturating adder. The narrow operand is
// zero-extended. carry flags that the true sum did not fit in ACC_W bits.
// When carry is set, the sum is clamped to all-ones.
module sum_sat_add #(
    parameter int ACC_W = 8,
    parameter int SUM_W = 3
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [SUM_W-1:0] val,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] wide;

    assign wide  = {1'b0, acc} + (ACC_W+1)'(val);
    assign carry = wide[ACC_W];
    assign sum   = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];

endmodule

// File: rtl/sum_accum.sv
// Frame accumulator for the adder stage's sums. It collects COUNT sums over
// a valid/ready handshake and then presents the saturating total, the peak
// value and an overflow flag. It holds the result until downstream takes
// it, and only then starts the next frame.
module sum_accum #(
    parameter int SUM_W = sum_pkg::SUM_W,
    parameter int COUNT = 4,   // 1..255
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [SUM_W-1:0] out_max,
    output logic             out_ovf,
    output logic             busy
);

    import sum_pkg::*;

    localparam int              CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [SUM_W-1:0] peak;
    logic [SUM_W-1:0] peak_next;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             carry;
    logic             accept;
    logic             last;
    logic             drain;
    logic [SUM_W-1:0] sum_gated;

    // Ready is forced low while reset is held. It is also low during HOLD,
    // so the HOLD->IDLE cycle can never take a sum.
    assign in_ready  = reset && (state != HOLD);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == LAST);
    assign drain     = (state == HOLD) && out_ready;
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    // Gate in_sum so that an unknown or stale value is never used when no
    // accept is happening.
    assign sum_gated = accept ? in_sum : '0;
    assign peak_next = (sum_gated > peak) ? sum_gated : peak;

    sum_sat_add #(
        .ACC_W(ACC_W),
        .SUM_W(SUM_W)
    ) u_sat_add (
        .acc  (acc),
        .val  (sum_gated),
        .sum  (acc_next),
        .carry(carry)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: all clocked state uses non-blocking assignments, so every
        // flop samples the values that were present before the edge.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state. clear overrides everything. A frame ends on the COUNTth
    // accept. HOLD is released by out_ready.
    always_comb begin
        // NOTE: the default assigned first covers every path, so no latch
        // is inferred.
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, ACCUM: if (accept) state_next = last ? HOLD : ACCUM;
                HOLD:        if (out_ready) state_next = IDLE;
                default:     state_next = IDLE;
            endcase
        end
    end

    // Running accumulator, peak, overflow and count. These are zeroed on
    // clear or when leaving HOLD, and otherwise advance on each accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            peak <= '0;
            ovf  <= 1'b0;
            cnt  <= '0;
        end else if (clear || drain) begin
            acc  <= '0;
            peak <= '0;
            ovf  <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            acc  <= acc_next;
            peak <= peak_next;
            ovf  <= ovf | carry;
            cnt  <= cnt + 1'b1;
        end
    end

    // Result registers. They are captured on the final accept of a frame
    // and stay stable for the whole of HOLD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_total <= '0;
            out_max   <= '0;
            out_ovf   <= 1'b0;
        end else if (accept && last && !clear) begin
            out_total <= acc_next;
            out_max   <= peak_next;
            out_ovf   <= ovf | carry;
        end
    end

endmodule
